rv_multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and write-back around the shared ALU, register file and a single unified memory port.
- Decodes the 7-bit opcode into per-cycle strobes: PC/IR/register-file write enables, mux selects and the memory request.
- Keeps a retired-instruction counter.

---
 rtl/rv_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/write-back sequencing and retire count.
// Optional memory-wait timeout with sticky bus_err when CTRL_MEM_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | halted, waiting for run
// FETCH  | instruction read from PC, IR load on mem_ready
// DECODE | opcode legality check
// EXEC   | branch resolve, or route to MEM/WB
// MEM    | load/store data access at ALU address
// WB     | register write and PC update
// TRAP   | illegal opcode or bus error, held until reset
module rv_multicycle_ctrl #(
   parameter int unsigned RESET_STATE_IDLE = 1,
   parameter int unsigned TIMEOUT_CYCLES   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic        take_branch,
   input  logic        mem_ready,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        ir_we,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        addr_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic        illegal,
`ifdef CTRL_MEM_TIMEOUT_EN
   output logic        bus_err,
`endif
   output logic [2:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam state_t RESET_STATE = (RESET_STATE_IDLE != 0) ? S_IDLE : S_FETCH;

   state_t      state_q, state_d;
   state_t      retire_next;
   logic        illegal_q, set_illegal;
   logic [31:0] instret_q;
   logic        mem_timeout;
   logic        is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_legal;

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_legal  = is_load || is_store || is_branch || is_jal || is_jalr || is_auipc ||
                      (opcode == OP_OPIMM) || (opcode == OP_OP) || (opcode == OP_LUI);

   // A retire with run low parks in IDLE only when IDLE is part of this build's flow.
   assign retire_next = (run || (RESET_STATE_IDLE == 0)) ? S_FETCH : S_IDLE;

`ifdef CTRL_MEM_TIMEOUT_EN
   localparam logic [7:0] WAIT_LIMIT = TIMEOUT_CYCLES[7:0];

   logic [7:0] wait_cnt;
   logic       bus_err_q;

   assign mem_timeout = ((state_q == S_FETCH) || (state_q == S_MEM)) && (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= 8'd0;
         bus_err_q <= 1'b0;
      end else begin
         if (state_d != state_q)
            wait_cnt <= 8'd0;
         else if (mem_req && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
         bus_err_q <= bus_err_q | mem_timeout;
      end
   end

   assign bus_err = bus_err_q;
`else
   assign mem_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RESET_STATE;
         illegal_q <= 1'b0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | set_illegal;
         if (pc_we)
            instret_q <= instret_q + 32'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      set_illegal = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 2'b00;
      ir_we       = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 2'b00;
      addr_sel    = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_timeout) begin
               state_d = S_TRAP;
            end else begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            if (is_legal) begin
               state_d = S_EXEC;
            end else begin
               set_illegal = 1'b1;
               state_d     = S_TRAP;
            end
         end
         S_EXEC: begin
            if (is_branch) begin
               pc_we   = 1'b1;
               pc_src  = take_branch ? 2'b01 : 2'b00;
               state_d = retire_next;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mem_timeout) begin
               state_d = S_TRAP;
            end else begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = is_store;
               if (mem_ready) begin
                  if (is_store) begin
                     pc_we   = 1'b1;
                     state_d = retire_next;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = retire_next;
            if (is_load)
               wb_sel = 2'b01;
            else if (is_jal || is_jalr)
               wb_sel = 2'b10;
            else if (is_auipc)
               wb_sel = 2'b11;
            if (is_jal)
               pc_src = 2'b01;
            else if (is_jalr)
               pc_src = 2'b10;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   assign illegal = illegal_q;
   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: per-instruction expectations are queued at issue and
// checked when the controller retires the instruction.
module tb_rv_multicycle_ctrl;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst_n, run, take_branch, mem_ready;
   logic [6:0]  opcode;
   logic        pc_we, ir_we, rf_we, addr_sel, mem_req, mem_we, illegal;
   logic [1:0]  pc_src, wb_sel;
   logic [2:0]  state;
   logic [31:0] instret;
`ifdef CTRL_MEM_TIMEOUT_EN
   logic        bus_err;
`endif

   always #5 clk = ~clk;

   rv_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .take_branch(take_branch),
      .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we),
      .wb_sel(wb_sel), .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we),
      .illegal(illegal),
`ifdef CTRL_MEM_TIMEOUT_EN
      .bus_err(bus_err),
`endif
      .state(state), .instret(instret)
   );

   typedef struct {
      logic [6:0] op;
      logic       tk;
      int         fw;
      int         mw;
   } stim_t;

   typedef struct {
      int          cycles;
      logic [1:0]  wb;
      logic [1:0]  pcs;
      int          rf;
      logic        mwe;
      int          mcyc;
      logic [31:0] ir;
   } exp_t;

   stim_t       stim_q[$];
   exp_t        exp_q[$];
   logic [31:0] model_instret;
   int          checks = 0;
   int          errors = 0;
   int          active_cycles;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] strobes();
      return {pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, pc_src, wb_sel, illegal};
   endfunction

   // Expectations come straight from the instruction-class table, not from the DUT.
   task automatic issue(input logic [6:0] op, input logic tk, input int fw, input int mw);
      stim_t s;
      exp_t  e;
      s = '{op: op, tk: tk, fw: fw, mw: mw};
      e = '{cycles: 4 + fw, wb: 2'b00, pcs: 2'b00, rf: 1, mwe: 1'b0, mcyc: 0, ir: model_instret};
      case (op)
         OP_LOAD:   begin e.cycles = 5 + fw + mw; e.wb = 2'b01; e.mcyc = mw + 1; end
         OP_STORE:  begin e.cycles = 4 + fw + mw; e.rf = 0; e.mwe = 1'b1; e.mcyc = mw + 1; end
         OP_BRANCH: begin e.cycles = 3 + fw; e.rf = 0; e.pcs = tk ? 2'b01 : 2'b00; end
         OP_JAL:    begin e.wb = 2'b10; e.pcs = 2'b01; end
         OP_JALR:   begin e.wb = 2'b10; e.pcs = 2'b10; end
         OP_AUIPC:  e.wb = 2'b11;
         default:   ;
      endcase
      model_instret++;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // Memory model and retire monitor: drive inputs just after the falling edge, sample 1 ns later.
   initial begin
      automatic bit    busy = 0;
      automatic int    fw_left = 0, mw_left = 0, cyc = 0, rf_cnt = 0, ir_cnt = 0, mcyc = 0;
      automatic logic  mem_bad = 0;
      automatic logic [1:0] wb_obs = 2'b00;
      automatic stim_t cur;
      automatic exp_t  e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0; cyc = 0; rf_cnt = 0; ir_cnt = 0; mcyc = 0; mem_bad = 0; wb_obs = 2'b00;
            mem_ready = 1'b0;
         end else begin
            if (state == 3'd1 && !busy && stim_q.size() > 0) begin
               cur = stim_q.pop_front();
               opcode = cur.op; take_branch = cur.tk;
               fw_left = cur.fw; mw_left = cur.mw;
               busy = 1;
            end
            mem_ready = 1'b0;
            if (state == 3'd1 && busy) begin
               if (fw_left == 0) mem_ready = 1'b1; else fw_left--;
            end
            if (state == 3'd4) begin
               if (mw_left == 0) mem_ready = 1'b1; else mw_left--;
            end
            #1;
            if (state >= 3'd1 && state <= 3'd5) begin
               cyc++;
               active_cycles++;
            end
            if (ir_we) ir_cnt++;
            if (rf_we) begin rf_cnt++; wb_obs = wb_sel; end
            if (state == 3'd4 && mem_req) begin
               mcyc++;
               if (exp_q.size() > 0 && (addr_sel !== 1'b1 || mem_we !== exp_q[0].mwe)) mem_bad = 1;
            end
            if (pc_we) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_retire", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("cycles", cyc, e.cycles);
                  chk("pc_src", {30'd0, pc_src}, {30'd0, e.pcs});
                  chk("rf_we_count", rf_cnt, e.rf);
                  if (e.rf != 0) chk("wb_sel", {30'd0, wb_obs}, {30'd0, e.wb});
                  chk("ir_we_count", ir_cnt, 1);
                  chk("mem_cycles", mcyc, e.mcyc);
                  chk("mem_qualifiers", {31'd0, mem_bad}, 32'd0);
                  chk("instret", instret, e.ir);
               end
               cyc = 0; rf_cnt = 0; ir_cnt = 0; mcyc = 0; mem_bad = 0; wb_obs = 2'b00;
               busy = 0;
               if (stim_q.size() == 0) run = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle(input int limit, input string tag);
      int n = 0;
      while (!(state == 3'd0 && exp_q.size() == 0) && n < limit) begin
         @(negedge clk); #2;
         n++;
      end
      chk(tag, {31'd0, n < limit}, 32'd1);
   endtask

   task automatic wait_state(input logic [2:0] target, input int limit, input string tag);
      int n = 0;
      while (state != target && n < limit) begin
         @(negedge clk); #2;
         n++;
      end
      chk(tag, {29'd0, state}, {29'd0, target});
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      rst_n = 1'b0; run = 1'b0;
      stim_q.delete(); exp_q.delete();
      model_instret = 32'd0;
      @(negedge clk); #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      automatic logic flag;
      rst_n = 1'b0; run = 1'b0; opcode = 7'd0; take_branch = 1'b0; mem_ready = 1'b0;
      model_instret = 32'd0;
      active_cycles = 0;
      #1;
      chk("reset_state", {29'd0, state}, 32'd0);
      chk("reset_strobes", {21'd0, strobes()}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         chk("idle_state", {29'd0, state}, 32'd0);
         chk("idle_strobes", {21'd0, strobes()}, 32'd0);
      end

      // ADDI stream, zero-wait memory
      for (int i = 0; i < 5; i++) issue(OP_OPIMM, 1'b0, 0, 0);
      active_cycles = 0;
      run = 1'b1;
      @(negedge clk); #2;
      chk("run_fetch_state", {29'd0, state}, 32'd1);
      chk("run_fetch_req", {31'd0, mem_req}, 32'd1);
      wait_idle(200, "addi_stream_done");
      chk("addi_instret", instret, 32'd5);
      chk("addi_total_cycles", active_cycles, 32'd20);

      // Mixed stream with wait states
      issue(OP_LOAD,   1'b0, 0, 3);
      issue(OP_BRANCH, 1'b1, 0, 0);
      issue(OP_BRANCH, 1'b0, 1, 0);
      issue(OP_JAL,    1'b0, 0, 0);
      issue(OP_JALR,   1'b0, 0, 0);
      issue(OP_STORE,  1'b0, 2, 1);
      issue(OP_LUI,    1'b0, 0, 0);
      issue(OP_AUIPC,  1'b0, 0, 0);
      issue(OP_OP,     1'b0, 0, 0);
      issue(OP_LOAD,   1'b0, 1, 0);
      issue(OP_STORE,  1'b0, 0, 0);
      run = 1'b1;
      wait_idle(400, "mixed_stream_done");
      chk("mixed_instret", instret, 32'd16);

      // Illegal opcode traps; run is ignored in TRAP
      stim_q.push_back('{op: 7'b0000000, tk: 1'b0, fw: 0, mw: 0});
      run = 1'b1;
      wait_state(3'd6, 20, "trap_state");
      chk("trap_illegal", {31'd0, illegal}, 32'd1);
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         if (mem_req || pc_we || ir_we || rf_we || state != 3'd6 || !illegal) flag = 1'b1;
      end
      chk("trap_hold", {31'd0, flag}, 32'd0);
      chk("trap_instret", instret, 32'd16);
      do_reset();
      chk("trap_reset_illegal", {31'd0, illegal}, 32'd0);
      chk("trap_reset_state", {29'd0, state}, 32'd0);

      // Reset asserted mid-FETCH aborts immediately
      issue(OP_OPIMM, 1'b0, 0, 0);
      stim_q.push_back('{op: OP_OPIMM, tk: 1'b0, fw: 6, mw: 0});
      run = 1'b1;
      begin
         int n = 0;
         while (!(instret == 32'd1 && state == 3'd1) && n < 50) begin
            @(negedge clk); #2;
            n++;
         end
         chk("midfetch_reached", {31'd0, n < 50}, 32'd1);
      end
      @(negedge clk); #2;
      chk("midfetch_req_held", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midfetch_strobes", {21'd0, strobes()}, 32'd0);
      chk("midfetch_state", {29'd0, state}, 32'd0);
      chk("midfetch_instret", instret, 32'd0);
      run = 1'b0;
      stim_q.delete(); exp_q.delete();
      model_instret = 32'd0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk); #2;
      chk("post_reset_idle", {29'd0, state}, 32'd0);

`ifdef CTRL_MEM_TIMEOUT_EN
      chk("bus_err_reset", {31'd0, bus_err}, 32'd0);
      stim_q.push_back('{op: OP_LOAD, tk: 1'b0, fw: 100000, mw: 0});
      run = 1'b1;
      wait_state(3'd6, 400, "timeout_trap");
      chk("timeout_bus_err", {31'd0, bus_err}, 32'd1);
      chk("timeout_req_dropped", {31'd0, mem_req}, 32'd0);
      chk("timeout_not_illegal", {31'd0, illegal}, 32'd0);
      do_reset();
      chk("timeout_reset_bus_err", {31'd0, bus_err}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
